mod_arbiter: RTL and testbench
==============================

MOD_ARBITER -- requirements
Module: mod_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand, result and quotient width; the bench SHALL use WIDTH=32.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  request from requester 0; held high until done with done_id=0 is seen.
REQ-005 a0, b0  input  WIDTH each  dividend and divisor of requester 0; held stable while req0=1.
REQ-006 req1  input  1  request from requester 1; same rules as req0.
REQ-007 a1, b1  input  WIDTH each  dividend and divisor of requester 1.
REQ-008 gnt0, gnt1  output  1 each  level grant; high while the engine is owned by that requester (RUN and DONE).
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 done_id  output  1  requester served by the current/last done.
REQ-012 result  output  WIDTH  remainder A mod B.
REQ-013 quotient  output  WIDTH  floor(A/B).
REQ-014 div_zero  output  1  high when the served request had B=0.

Function
REQ-015 FSM SHALL have states IDLE, RUN, DONE; only IDLE arbitrates.
REQ-016 IDLE, no req: remain in IDLE; gnt0=gnt1=busy=done=0.
REQ-017 IDLE, one req: at the edge, latch winner's A into temp, B into div, clear iteration count, set owner id, go to RUN (to DONE if B=0).
REQ-018 IDLE, both req: winner SHALL be the requester not served last (round-robin via last_id); loser waits, its req stays pending.
REQ-019 RUN, temp < div: latch result<=temp, quotient<=count, div_zero<=0, go to DONE.
REQ-020 RUN, temp >= div: temp<=temp-div, count<=count+1, stay in RUN; unsigned WIDTH-bit arithmetic, no wrap possible since temp>=div.
REQ-021 B=0 at acceptance: go directly to DONE with result=A, quotient=all ones, div_zero=1; no RUN cycles.
REQ-022 DONE: done=1 and done_id=owner for exactly one cycle; next edge: last_id<=owner, go to IDLE.
REQ-023 Latency: with acceptance at edge k and N=floor(A/B), RUN lasts N+1 cycles; done is high in the cycle after edge k+N+1.
REQ-024 result, quotient, div_zero, done_id SHALL hold their values from DONE until the next DONE or reset.
REQ-025 Requester SHALL drop req at the edge ending its DONE cycle; a req still high in the following IDLE cycle is a new request.
REQ-026 a/b/req changes during RUN SHALL not affect the operation in progress (operands latched).
REQ-027 gnt0/gnt1 SHALL be one-hot or zero, never both high.

Reset
REQ-028 reset=1 at a rising edge: state<=IDLE; temp, div, count, result, quotient<=0; div_zero, done, done_id<=0; last_id<=1 (requester 0 wins first tie).
REQ-029 Reset during RUN or DONE SHALL abort with no done pulse; pending requests are re-arbitrated after reset deasserts.
REQ-030 Reset has priority over all other events in the same cycle.

Verification
REQ-031 req0, a0=17, b0=5 -> RUN 4 cycles; done=1, done_id=0, result=2, quotient=3, div_zero=0; gnt0 high RUN..DONE.
REQ-032 a0=3, b0=7 -> single RUN cycle; done in cycle after edge k+1, result=3, quotient=0.
REQ-033 req0 and req1 raised together after reset, (a0,b0)=(10,3), (a1,b1)=(9,4) -> req0 served first (result=1, quotient=3), then req1 (result=1, quotient=2, done_id=1); then repeat both -> req0 again (last_id=1).
REQ-034 req1, a1=42, b1=0 -> DONE immediately after acceptance; result=42, quotient=0xFFFFFFFF, div_zero=1, no RUN cycle.
REQ-035 req0, a0=100, b0=1; reset pulse at 5th RUN cycle -> no done, all outputs 0, IDLE; req0 still high -> re-accepted, later result=0, quotient=100.
REQ-036 a0=0xFFFFFFFF, b0=0xFFFFFFFF -> result=0, quotient=1; a0=0, b0=9 -> result=0, quotient=0.

Source files
------------

// File: rtl/mod_arbiter_if.sv
// Request/operand bus between two requesters and the shared divider engine.
interface mod_arbiter_if #(
   parameter int unsigned WIDTH = 32
);
   logic             req0;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   logic             req1;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic             gnt0;
   logic             gnt1;
   logic             busy;
   logic             done;
   logic             done_id;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] quotient;
   logic             div_zero;

   modport slave (
      input  req0, a0, b0, req1, a1, b1,
      output gnt0, gnt1, busy, done, done_id, result, quotient, div_zero
   );

   modport master (
      output req0, a0, b0, req1, a1, b1,
      input  gnt0, gnt1, busy, done, done_id, result, quotient, div_zero
   );
endinterface

// File: rtl/mod_arbiter.sv
// Two-requester round-robin arbiter in front of a shared iterative
// subtract-based divider; one operation in flight at a time.
module mod_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic          clk,
   input  logic          reset,
   mod_arbiter_if.slave  bus_if
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_temp;
   logic [WIDTH-1:0] w_temp_nxt;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] w_div_nxt;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_nxt;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] w_result_nxt;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] w_quotient_nxt;
   logic             r_owner;
   logic             w_owner_nxt;
   logic             r_last_id;
   logic             w_last_id_nxt;
   logic             r_div_zero;
   logic             w_div_zero_nxt;
   logic             r_done_id;
   logic             w_done_id_nxt;
   logic             r_done;
   logic             r_busy;
   logic             r_gnt0;
   logic             r_gnt1;
   logic             w_winner;
   logic [WIDTH-1:0] w_sel_a;
   logic [WIDTH-1:0] w_sel_b;

   // On a tie the requester that was not served last wins.
   always_comb begin
      w_winner = (bus_if.req0 && bus_if.req1) ? ~r_last_id : bus_if.req1;
      w_sel_a  = w_winner ? bus_if.a1 : bus_if.a0;
      w_sel_b  = w_winner ? bus_if.b1 : bus_if.b0;
   end

   // Next-state and datapath update.
   always_comb begin
      w_state_nxt    = r_state;
      w_temp_nxt     = r_temp;
      w_div_nxt      = r_div;
      w_count_nxt    = r_count;
      w_result_nxt   = r_result;
      w_quotient_nxt = r_quotient;
      w_owner_nxt    = r_owner;
      w_last_id_nxt  = r_last_id;
      w_div_zero_nxt = r_div_zero;
      w_done_id_nxt  = r_done_id;

      case (r_state)
         S_IDLE: begin
            if (bus_if.req0 || bus_if.req1) begin
               w_owner_nxt = w_winner;
               w_temp_nxt  = w_sel_a;
               w_div_nxt   = w_sel_b;
               w_count_nxt = '0;
               if (w_sel_b == '0) begin
                  // Divide by zero skips the iteration entirely.
                  w_result_nxt   = w_sel_a;
                  w_quotient_nxt = '1;
                  w_div_zero_nxt = 1'b1;
                  w_done_id_nxt  = w_winner;
                  w_state_nxt    = S_DONE;
               end else begin
                  w_state_nxt = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (r_temp < r_div) begin
               w_result_nxt   = r_temp;
               w_quotient_nxt = r_count;
               w_div_zero_nxt = 1'b0;
               w_done_id_nxt  = r_owner;
               w_state_nxt    = S_DONE;
            end else begin
               w_temp_nxt  = r_temp - r_div;
               w_count_nxt = r_count + WIDTH'(1);
            end
         end
         S_DONE: begin
            w_last_id_nxt = r_owner;
            w_state_nxt   = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, datapath and registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_temp     <= '0;
         r_div      <= '0;
         r_count    <= '0;
         r_result   <= '0;
         r_quotient <= '0;
         r_owner    <= 1'b0;
         r_last_id  <= 1'b1;
         r_div_zero <= 1'b0;
         r_done_id  <= 1'b0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
         r_gnt0     <= 1'b0;
         r_gnt1     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_temp     <= w_temp_nxt;
         r_div      <= w_div_nxt;
         r_count    <= w_count_nxt;
         r_result   <= w_result_nxt;
         r_quotient <= w_quotient_nxt;
         r_owner    <= w_owner_nxt;
         r_last_id  <= w_last_id_nxt;
         r_div_zero <= w_div_zero_nxt;
         r_done_id  <= w_done_id_nxt;
         r_done     <= (w_state_nxt == S_DONE);
         r_busy     <= (w_state_nxt != S_IDLE);
         r_gnt0     <= (w_state_nxt != S_IDLE) && !w_owner_nxt;
         r_gnt1     <= (w_state_nxt != S_IDLE) &&  w_owner_nxt;
      end
   end

   assign bus_if.gnt0     = r_gnt0;
   assign bus_if.gnt1     = r_gnt1;
   assign bus_if.busy     = r_busy;
   assign bus_if.done     = r_done;
   assign bus_if.done_id  = r_done_id;
   assign bus_if.result   = r_result;
   assign bus_if.quotient = r_quotient;
   assign bus_if.div_zero = r_div_zero;

endmodule

// File: tb/tb_mod_arbiter.sv
// Scoreboard bench for mod_arbiter: directed requests push expected
// completions; a forked monitor pops and compares on every done pulse.
module tb_mod_arbiter;

   localparam int unsigned WIDTH = 32;

   typedef struct packed {
      logic             id;
      logic [WIDTH-1:0] res;
      logic [WIDTH-1:0] quo;
      logic             dz;
   } exp_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   exp_t sb[$];

   mod_arbiter_if #(.WIDTH(WIDTH)) bus_if ();

   mod_arbiter #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus_if (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic id, input logic [WIDTH-1:0] res,
                           input logic [WIDTH-1:0] quo, input logic dz);
      exp_t e;
      e.id  = id;
      e.res = res;
      e.quo = quo;
      e.dz  = dz;
      sb.push_back(e);
   endtask

   // Pops one expectation per done pulse and compares payload and grants.
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && bus_if.done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 72'(bus_if.done), 72'(0));
            end else begin
               e = sb.pop_front();
               check("done_payload",
                     72'({bus_if.done_id, bus_if.result, bus_if.quotient, bus_if.div_zero}),
                     72'(e));
               check("done_grant",
                     72'({bus_if.gnt0, bus_if.gnt1, bus_if.busy}),
                     72'({~e.id, e.id, 1'b1}));
            end
         end
      end
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      bus_if.req0 = 1'b0;
      bus_if.req1 = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int n, output bit got);
      n   = 0;
      got = 1'b0;
      while (!got && n < budget) begin
         @(negedge clk);
         n++;
         if (bus_if.done) got = 1'b1;
      end
   endtask

   // One request from requester id; lat = negedges from raise to done.
   task automatic single(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] res, input logic [WIDTH-1:0] quo,
                         input logic dz, input int lat, input bit scramble);
      int n;
      bit got;
      push_exp(id, res, quo, dz);
      if (id) begin
         bus_if.a1 = a; bus_if.b1 = b; bus_if.req1 = 1'b1;
      end else begin
         bus_if.a0 = a; bus_if.b0 = b; bus_if.req0 = 1'b1;
      end
      n   = 0;
      got = 1'b0;
      while (!got && n < 400) begin
         @(negedge clk);
         n++;
         if (n == 1 && lat > 1)
            check("run_grant",
                  72'({bus_if.gnt0, bus_if.gnt1, bus_if.busy, bus_if.done}),
                  72'({~id, id, 1'b1, 1'b0}));
         if (n == 1 && scramble) begin
            bus_if.a0 = 32'hDEAD_BEEF; bus_if.b0 = 32'd1;
            bus_if.a1 = 32'hDEAD_BEEF; bus_if.b1 = 32'd1;
         end
         if (bus_if.done) got = 1'b1;
      end
      bus_if.req0 = 1'b0;
      bus_if.req1 = 1'b0;
      check("latency", 72'(n), 72'(lat));
      @(negedge clk);
   endtask

   // Both requesters raised together: 10/3 on req0, 9/4 on req1.
   task automatic pair();
      int n;
      push_exp(1'b0, 32'd1, 32'd3, 1'b0);
      push_exp(1'b1, 32'd1, 32'd2, 1'b0);
      bus_if.a0 = 32'd10; bus_if.b0 = 32'd3;
      bus_if.a1 = 32'd9;  bus_if.b1 = 32'd4;
      bus_if.req0 = 1'b1;
      bus_if.req1 = 1'b1;
      n = 0;
      while ((bus_if.req0 || bus_if.req1) && n < 400) begin
         @(negedge clk);
         n++;
         if (n == 1)
            check("tie_winner", 72'({bus_if.gnt0, bus_if.gnt1}), 72'(2'b10));
         if (bus_if.done) begin
            if (bus_if.done_id) bus_if.req1 = 1'b0;
            else                bus_if.req0 = 1'b0;
         end
      end
      check("pair_time", 72'(n), 72'(10));
      @(negedge clk);
   endtask

   // Reset in the 5th RUN cycle of 100/1, then re-acceptance of held req0.
   task automatic abort_test();
      int n;
      bit got;
      bus_if.a0   = 32'd100;
      bus_if.b0   = 32'd1;
      bus_if.req0 = 1'b1;
      repeat (5) @(negedge clk);
      check("abort_pre", 72'({bus_if.busy, bus_if.done}), 72'(2'b10));
      reset = 1'b1;
      @(negedge clk);
      check("abort_cleared",
            72'({bus_if.gnt0, bus_if.gnt1, bus_if.busy, bus_if.done, bus_if.done_id,
                 bus_if.div_zero, bus_if.result, bus_if.quotient}),
            72'(0));
      reset = 1'b0;
      push_exp(1'b0, 32'd0, 32'd100, 1'b0);
      wait_done(400, n, got);
      bus_if.req0 = 1'b0;
      check("abort_relatency", 72'(n), 72'(102));
      @(negedge clk);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      bus_if.a0 = '0;
      bus_if.b0 = '0;
      bus_if.a1 = '0;
      bus_if.b1 = '0;
      fork
         monitor();
      join_none

      do_reset();
      check("reset_state",
            72'({bus_if.gnt0, bus_if.gnt1, bus_if.busy, bus_if.done, bus_if.done_id,
                 bus_if.div_zero, bus_if.result, bus_if.quotient}),
            72'(0));

      single(1'b0, 32'd17, 32'd5, 32'd2, 32'd3, 1'b0, 5, 1'b1);
      single(1'b0, 32'd3,  32'd7, 32'd3, 32'd0, 1'b0, 2, 1'b0);

      do_reset();
      pair();
      pair();

      single(1'b1, 32'd42, 32'd0, 32'd42, 32'hFFFF_FFFF, 1'b1, 1, 1'b0);
      check("hold_after_done",
            72'({bus_if.done, bus_if.done_id, bus_if.div_zero, bus_if.result}),
            72'({1'b0, 1'b1, 1'b1, 32'd42}));
      single(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 3, 1'b0);
      single(1'b0, 32'd0, 32'd9, 32'd0, 32'd0, 1'b0, 2, 1'b0);

      abort_test();

      repeat (3) @(negedge clk);
      check("sb_drained", 72'(sb.size()), 72'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
